// File: rtl/game_pkg.sv
// Shared types, default constants and arithmetic helpers for the game state tracker.
package game_pkg;

  typedef enum logic [1:0] {
    PLAYING   = 2'd0,
    HURT      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  localparam int DEF_ENEMY_NUM   = 4;
  localparam int DEF_BLOOD_W     = 10;
  localparam int DEF_FULL_BLOOD  = 100;
  localparam int DEF_DAMAGE      = 5;
  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_KILL_POINTS = 1;
  localparam int DEF_INV_FRAMES  = 30;
  localparam int DEF_HOLD_FRAMES = 60;

  // Unsigned add that clamps at max_val instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

  // Number of bits needed to hold values 0..max_val, never less than one.
  function automatic int bits_for(input int max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hit_popcount.sv
// Combinational population count of an N-bit event vector.
module hit_popcount #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] count
);

  // Sum the individual event bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(vec[i]);
    end
  end

endmodule

// File: rtl/game_state_tracker.sv
// Frame-synchronous player health / score tracker with invulnerability
// window and a latched, timed game-over state.
module game_state_tracker
  import game_pkg::*;
#(
  parameter int ENEMY_NUM   = DEF_ENEMY_NUM,
  parameter int BLOOD_W     = DEF_BLOOD_W,
  parameter int FULL_BLOOD  = DEF_FULL_BLOOD,
  parameter int DAMAGE      = DEF_DAMAGE,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int KILL_POINTS = DEF_KILL_POINTS,
  parameter int INV_FRAMES  = DEF_INV_FRAMES,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 game_frame_clk_rising_edge,
  input  logic [ENEMY_NUM-1:0] Enemy_Attack_Hit,
  input  logic [ENEMY_NUM-1:0] Enemy_Kill,
  input  logic                 Restart,
  output logic [BLOOD_W-1:0]   Player_Blood,
  output logic [SCORE_W-1:0]   Total_Score,
  output logic                 Game_Over_On,
  output logic                 Invuln_On,
  output logic                 Restart_Ready
);

  // Count width for popcounts, and a product width wide enough for the
  // worst case of every enemy contributing the larger per-event weight.
  localparam int CW    = $clog2(ENEMY_NUM + 1);
  localparam int MAXPT = (DAMAGE > KILL_POINTS) ? DAMAGE : KILL_POINTS;
  localparam int DW    = bits_for(ENEMY_NUM * MAXPT);
  localparam int IW    = bits_for(INV_FRAMES);
  localparam int HW    = bits_for(HOLD_FRAMES);

  localparam logic [31:0] SCORE_MAX = (SCORE_W >= 32) ? 32'hFFFF_FFFF
                                    : 32'((64'd1 << SCORE_W) - 64'd1);

  game_state_t        state_reg, state_next;
  logic [BLOOD_W-1:0] blood_reg, blood_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [IW-1:0]      inv_cnt_reg, inv_cnt_next;
  logic [HW-1:0]      hold_cnt_reg, hold_cnt_next;

  logic [CW-1:0] hits;
  logic [CW-1:0] kills;
  logic [DW-1:0] dmg;
  logic [DW-1:0] pts;
  logic          hold_done;
  logic          lethal;

  hit_popcount #(.N(ENEMY_NUM), .W(CW)) u_hit_count (
    .vec   (Enemy_Attack_Hit),
    .count (hits)
  );

  hit_popcount #(.N(ENEMY_NUM), .W(CW)) u_kill_count (
    .vec   (Enemy_Kill),
    .count (kills)
  );

  assign dmg       = DW'(hits) * DW'(DAMAGE);
  assign pts       = DW'(kills) * DW'(KILL_POINTS);
  assign lethal    = 32'(dmg) >= 32'(blood_reg);
  assign hold_done = (hold_cnt_reg == HW'(HOLD_FRAMES));

  // State, health, score and counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= PLAYING;
      blood_reg    <= BLOOD_W'(FULL_BLOOD);
      score_reg    <= '0;
      inv_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      blood_reg    <= blood_next;
      score_reg    <= score_next;
      inv_cnt_reg  <= inv_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Next-state logic; everything holds unless a frame tick arrives.
  always_comb begin
    state_next    = state_reg;
    blood_next    = blood_reg;
    score_next    = score_reg;
    inv_cnt_next  = inv_cnt_reg;
    hold_cnt_next = hold_cnt_reg;

    if (game_frame_clk_rising_edge) begin
      case (state_reg)
        PLAYING: begin
          // Kill points land before any lethal hit is resolved.
          score_next = SCORE_W'(sat_add(32'(score_reg), 32'(pts), SCORE_MAX));
          if (hits != '0) begin
            if (lethal) begin
              blood_next    = '0;
              state_next    = GAME_OVER;
              hold_cnt_next = '0;
            end else begin
              blood_next   = blood_reg - BLOOD_W'(dmg);
              state_next   = HURT;
              inv_cnt_next = IW'(INV_FRAMES - 1);
            end
          end
        end

        HURT: begin
          // Hits are ignored while invulnerable; kills still count.
          score_next = SCORE_W'(sat_add(32'(score_reg), 32'(pts), SCORE_MAX));
          if (inv_cnt_reg == '0) begin
            state_next = PLAYING;
          end else begin
            inv_cnt_next = inv_cnt_reg - IW'(1);
          end
        end

        GAME_OVER: begin
          // A restart only counts once the hold window has fully elapsed.
          if (hold_done && Restart) begin
            state_next    = PLAYING;
            blood_next    = BLOOD_W'(FULL_BLOOD);
            score_next    = '0;
            hold_cnt_next = '0;
            inv_cnt_next  = '0;
          end else if (!hold_done) begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
          end
        end

        default: begin
          state_next = PLAYING;
        end
      endcase
    end
  end

  assign Player_Blood  = blood_reg;
  assign Total_Score   = score_reg;
  assign Game_Over_On  = (state_reg == GAME_OVER);
  assign Invuln_On     = (state_reg == HURT);
  assign Restart_Ready = (state_reg == GAME_OVER) && hold_done;

endmodule

// File: tb/tb_game_state_tracker.sv
// Directed self-checking bench for game_state_tracker (default parameters).
module tb_game_state_tracker;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] hit;
  logic [3:0] kill;
  logic       restart;
  logic [9:0] blood;
  logic [7:0] score;
  logic       game_over;
  logic       invuln;
  logic       ready;

  int vectors;
  int miscompares;

  game_state_tracker dut (
    .Clk                        (clk),
    .Reset                      (reset),
    .game_frame_clk_rising_edge (tick),
    .Enemy_Attack_Hit           (hit),
    .Enemy_Kill                 (kill),
    .Restart                    (restart),
    .Player_Blood               (blood),
    .Total_Score                (score),
    .Game_Over_On               (game_over),
    .Invuln_On                  (invuln),
    .Restart_Ready              (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame tick with the given event vectors; outputs are stable on return.
  task automatic do_tick(input logic [3:0] h, input logic [3:0] k, input logic r);
    hit = h; kill = k; restart = r; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; hit = '0; kill = '0; restart = 1'b0;
  endtask

  task automatic check_all(input string tag, input int b, input int s,
                           input int go, input int inv, input int rdy);
    check({tag, "_blood"}, int'(blood), b);
    check({tag, "_score"}, int'(score), s);
    check({tag, "_game_over"}, int'(game_over), go);
    check({tag, "_invuln"}, int'(invuln), inv);
    check({tag, "_ready"}, int'(ready), rdy);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; tick = 1'b0; hit = '0; kill = '0; restart = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check_all("reset", 100, 0, 0, 0, 0);

    // Idle ticks change nothing.
    for (int i = 0; i < 3; i++) do_tick(4'b0000, 4'b0000, 1'b0);
    check_all("idle", 100, 0, 0, 0, 0);

    // Two hits: 10 damage, then a 30-tick invulnerability window.
    do_tick(4'b0101, 4'b0000, 1'b0);
    check_all("hit2", 90, 0, 0, 1, 0);
    for (int i = 1; i <= 30; i++) begin
      do_tick(4'b1111, 4'b0000, 1'b0);
      if (i == 29) check_all("hurt29", 90, 0, 0, 1, 0);
      if (i == 30) check_all("hurt30", 90, 0, 0, 0, 0);
    end

    // Four 20-point hits bring health 90 -> 10; kills during HURT score.
    for (int r = 0; r < 4; r++) begin
      do_tick(4'b1111, 4'b0000, 1'b0);
      check("round_blood", int'(blood), 70 - 20 * r);
      check("round_invuln", int'(invuln), 1);
      for (int j = 0; j < 30; j++) begin
        do_tick(4'b1111, (r == 0 && j == 0) ? 4'b0011 : 4'b0000, 1'b0);
      end
      check("round_score", int'(score), 2);
      check("round_back", int'(invuln), 0);
    end

    // Lethal hit with a simultaneous kill: point counted, then game over.
    do_tick(4'b1111, 4'b0001, 1'b0);
    check_all("lethal", 0, 3, 1, 0, 0);

    // Hold window: events ignored, early restart ignored, ready after tick 60.
    for (int i = 1; i <= 60; i++) begin
      do_tick((i <= 3) ? 4'b1111 : 4'b0000, (i <= 3) ? 4'b1111 : 4'b0000, i == 10);
      if (i == 3)  check_all("go_ignore", 0, 3, 1, 0, 0);
      if (i == 10) check_all("go_early_restart", 0, 3, 1, 0, 0);
      if (i == 59) check("go_ready59", int'(ready), 0);
      if (i == 60) check_all("go_ready60", 0, 3, 1, 0, 1);
    end
    do_tick(4'b0000, 4'b0000, 1'b1);
    check_all("restart", 100, 0, 0, 0, 0);

    // Score saturation: 4 points per tick, 255 reached at tick 64.
    for (int i = 1; i <= 70; i++) begin
      do_tick(4'b0000, 4'b1111, 1'b0);
      if (i == 1)  check("sat1", int'(score), 4);
      if (i == 63) check("sat63", int'(score), 252);
      if (i == 64) check("sat64", int'(score), 255);
      if (i == 70) check("sat70", int'(score), 255);
    end

    // Events without a tick never change state.
    hit = 4'b1111; kill = 4'b1111; restart = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    hit = '0; kill = '0; restart = 1'b0;
    check_all("no_tick", 100, 255, 0, 0, 0);

    // Reset in the middle of HURT (inv_cnt = 12).
    do_tick(4'b0101, 4'b0000, 1'b0);
    for (int i = 0; i < 17; i++) do_tick(4'b0000, 4'b0000, 1'b0);
    check_all("mid_hurt", 90, 255, 0, 1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("reset_mid_hurt", 100, 0, 0, 0, 0);
    do_tick(4'b0000, 4'b0000, 1'b0);
    check_all("post_reset", 100, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
